// File: rtl/log_mult_pkg.sv
// Shared constants and helpers for the 8-bit logarithmic multiplier.
// ceil_log2 is the reference for the log-value stage.
package log_mult_pkg;
  localparam int DATA_W = 8;
  localparam int LOG_W  = 4;
  localparam int OUT_W  = 2 * DATA_W;

  function automatic logic is_pow2(input logic [DATA_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Returns 0 for inputs 0 and 1.
  function automatic logic [LOG_W-1:0] ceil_log2(input logic [DATA_W-1:0] v);
    logic [LOG_W-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if ((32'd1 << i) < 32'(v)) k = LOG_W'(i + 1);
    end
    return k;
  endfunction
endpackage

// File: rtl/log_mult_antilog_pipe_if.sv
// Operand and product handshake bundle for the antilog pipeline.
// A transfer happens on a rising edge where valid and ready are both 1; a
// producer holds valid and its payload until that edge, and ready never waits on valid.
interface log_mult_antilog_pipe_if;
  import log_mult_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic [LOG_W-1:0]  log_x;
  logic [LOG_W-1:0]  log_y;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_prod;
  logic              out_exact;

  modport master (
    output in_valid, in_x, in_y, log_x, log_y, out_ready,
    input  in_ready, out_valid, out_prod, out_exact
  );

  modport slave (
    input  in_valid, in_x, in_y, log_x, log_y, out_ready,
    output in_ready, out_valid, out_prod, out_exact
  );
endinterface

// File: rtl/log_mult_term_gen.sv
// Stage-1 term generator: shifted operands, the 2^(kx+ky) correction term,
// and the zero/exact flags.
module log_mult_term_gen
  import log_mult_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [LOG_W-1:0]  kx,
  input  logic [LOG_W-1:0]  ky,
  output logic [OUT_W-1:0]  tx,
  output logic [OUT_W-1:0]  ty,
  output logic [OUT_W:0]    tk,
  output logic              z,
  output logic              e
);
  logic [LOG_W:0] ksum;

  always_comb begin
    ksum = {1'b0, kx} + {1'b0, ky};
    tx   = OUT_W'(x) << ky;
    ty   = OUT_W'(y) << kx;
    // kx + ky reaches 16 for 255*255, hence the 17-bit term.
    tk   = (OUT_W + 1)'(1) << ksum;
    z    = (x == '0) | (y == '0);
    e    = z | is_pow2(x) | is_pow2(y);
  end
endmodule

// File: rtl/log_mult_antilog_pipe.sv
// Three-stage Mitchell antilog pipeline: P = x*2^ky + y*2^kx - 2^(kx+ky).
// All stages advance together whenever the output stage is empty or drained.
module log_mult_antilog_pipe
  import log_mult_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  log_mult_antilog_pipe_if.slave  bus
);
  logic [OUT_W-1:0] tx, ty;
  logic [OUT_W:0]   tk;
  logic             z, e;
  logic             adv;

  logic             s1_valid_d, s1_valid_q;
  logic [OUT_W-1:0] s1_tx_d, s1_tx_q, s1_ty_d, s1_ty_q;
  logic [OUT_W:0]   s1_tk_d, s1_tk_q;
  logic             s1_z_d, s1_z_q, s1_e_d, s1_e_q;
  logic             s2_valid_d, s2_valid_q;
  logic [OUT_W+1:0] s2_sum_d, s2_sum_q;
  logic             s2_z_d, s2_z_q, s2_e_d, s2_e_q;
  logic             s3_valid_d, s3_valid_q;
  logic [OUT_W-1:0] out_prod_d, out_prod_q;
  logic             out_exact_d, out_exact_q;

  log_mult_term_gen u_term_gen (
    .x  (bus.in_x),
    .y  (bus.in_y),
    .kx (bus.log_x),
    .ky (bus.log_y),
    .tx (tx),
    .ty (ty),
    .tk (tk),
    .z  (z),
    .e  (e)
  );

  assign adv           = !s3_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_valid_q;
  assign bus.out_prod  = out_prod_q;
  assign bus.out_exact = out_exact_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_tx_d     = s1_tx_q;
    s1_ty_d     = s1_ty_q;
    s1_tk_d     = s1_tk_q;
    s1_z_d      = s1_z_q;
    s1_e_d      = s1_e_q;
    s2_valid_d  = s2_valid_q;
    s2_sum_d    = s2_sum_q;
    s2_z_d      = s2_z_q;
    s2_e_d      = s2_e_q;
    s3_valid_d  = s3_valid_q;
    out_prod_d  = out_prod_q;
    out_exact_d = out_exact_q;
    if (adv) begin
      s1_valid_d  = bus.in_valid;
      s1_tx_d     = tx;
      s1_ty_d     = ty;
      s1_tk_d     = tk;
      s1_z_d      = z;
      s1_e_d      = e;
      s2_valid_d  = s1_valid_q;
      // Wraps for a zero operand; the zero flag masks that in stage 3.
      s2_sum_d    = {2'b00, s1_tx_q} + {2'b00, s1_ty_q} - {1'b0, s1_tk_q};
      s2_z_d      = s1_z_q;
      s2_e_d      = s1_e_q;
      s3_valid_d  = s2_valid_q;
      out_prod_d  = s2_z_q ? '0 : s2_sum_q[OUT_W-1:0];
      out_exact_d = s2_e_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_tx_q     <= '0;
      s1_ty_q     <= '0;
      s1_tk_q     <= '0;
      s1_z_q      <= 1'b0;
      s1_e_q      <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_z_q      <= 1'b0;
      s2_e_q      <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_prod_q  <= '0;
      out_exact_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_tx_q     <= s1_tx_d;
      s1_ty_q     <= s1_ty_d;
      s1_tk_q     <= s1_tk_d;
      s1_z_q      <= s1_z_d;
      s1_e_q      <= s1_e_d;
      s2_valid_q  <= s2_valid_d;
      s2_sum_q    <= s2_sum_d;
      s2_z_q      <= s2_z_d;
      s2_e_q      <= s2_e_d;
      s3_valid_q  <= s3_valid_d;
      out_prod_q  <= out_prod_d;
      out_exact_q <= out_exact_d;
      // With consistent logs a nonzero product never exceeds 16 bits.
      if (s2_valid_q && !s2_z_q) assert (s2_sum_q[OUT_W+1:OUT_W] == 2'b00);
    end
  end
endmodule

// File: tb/tb_log_mult_antilog_pipe.sv
// Directed bench for log_mult_antilog_pipe: latency, edge operands, stalled
// streaming and mid-flight reset, checked against hand-computed products.
module tb_log_mult_antilog_pipe;
  import log_mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  log_mult_antilog_pipe_if io ();

  log_mult_antilog_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [OUT_W:0] exp_q[$];  // {exact, prod}
  int or_mode = 0;           // 0: out_ready low, 1: high, 2: 1,0,0,1 pattern

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // out_ready driver
  initial begin
    logic [3:0] pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    io.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       io.out_ready = 1'b0;
        1:       io.out_ready = 1'b1;
        default: begin
          io.out_ready = pat[idx];
          idx = (idx + 1) % 4;
        end
      endcase
    end
  end

  // Scoreboard and stall-stability monitor
  logic             hold_pending = 1'b0;
  logic [OUT_W-1:0] held_prod;
  logic             held_exact;
  always @(negedge clk) begin
    logic [OUT_W:0] e;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(io.out_valid), 32'd1);
        check("hold_prod", 32'(io.out_prod), 32'(held_prod));
        check("hold_exact", 32'(io.out_exact), 32'(held_exact));
      end
      check("in_ready", 32'(io.in_ready), 32'(!(io.out_valid && !io.out_ready)));
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(io.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("prod", 32'(io.out_prod), 32'(e[OUT_W-1:0]));
          check("exact", 32'(io.out_exact), 32'(e[OUT_W]));
        end
      end
      hold_pending = io.out_valid && !io.out_ready;
      held_prod    = io.out_prod;
      held_exact   = io.out_exact;
    end
  end

  // Presents one pair and returns at posedge+1 after it is accepted.
  task automatic drive(input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] kx, input logic [3:0] ky);
    int n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    io.in_valid = 1'b1;
    io.in_x     = x;
    io.in_y     = y;
    io.log_x    = kx;
    io.log_y    = ky;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = io.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 32'(io.in_ready), 32'd1);
    io.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [3:0] kx, input logic [3:0] ky,
                      input logic [15:0] prod, input logic exact);
    exp_q.push_back({exact, prod});
    drive(x, y, kx, ky);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    io.in_valid = 1'b0;
    io.in_x     = '0;
    io.in_y     = '0;
    io.log_x    = '0;
    io.log_y    = '0;
    rst         = 1'b1;
    or_mode     = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_out_prod", 32'(io.out_prod), 32'd0);
    check("rst_out_exact", 32'(io.out_exact), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (5) begin
      @(negedge clk);
      check("idle_out_valid", 32'(io.out_valid), 32'd0);
      check("idle_in_ready", 32'(io.in_ready), 32'd1);
    end
    @(posedge clk);
    #1;

    // 8*8: visible after the third edge counting the accept edge
    exp_q.push_back({1'b1, 16'd64});
    io.in_valid = 1'b1;
    io.in_x = 8'd8; io.in_y = 8'd8; io.log_x = 4'd3; io.log_y = 4'd3;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge3", 32'(io.out_valid), 32'd1);
    @(posedge clk);
    #1;

    send(8'd6,   8'd5,   4'd3, 4'd3, 16'd24,    1'b0); wait_drain();
    send(8'd255, 8'd255, 4'd8, 4'd8, 16'd65024, 1'b0); wait_drain();
    send(8'd1,   8'd77,  4'd0, 4'd7, 16'd77,    1'b1); wait_drain();
    send(8'd0,   8'd200, 4'd0, 4'd8, 16'd0,     1'b1); wait_drain();

    // Back-to-back stream under a 1,0,0,1 out_ready pattern
    or_mode = 2;
    send(8'd3,   8'd3,   4'd2, 4'd2, 16'd8,    1'b0);
    send(8'd10,  8'd12,  4'd4, 4'd4, 16'd96,   1'b0);
    send(8'd16,  8'd9,   4'd4, 4'd4, 16'd144,  1'b1);
    send(8'd7,   8'd7,   4'd3, 4'd3, 16'd48,   1'b0);
    send(8'd100, 8'd3,   4'd7, 4'd2, 16'd272,  1'b0);
    send(8'd2,   8'd200, 4'd1, 4'd8, 16'd400,  1'b1);
    send(8'd129, 8'd129, 4'd8, 4'd8, 16'd512,  1'b0);
    send(8'd0,   8'd5,   4'd0, 4'd3, 16'd0,    1'b1);
    send(8'd255, 8'd1,   4'd8, 4'd0, 16'd255,  1'b1);
    send(8'd50,  8'd60,  4'd6, 4'd6, 16'd2944, 1'b0);
    wait_drain();

    // Three in flight, then reset: none of them may emerge
    or_mode = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    drive(8'd9,  8'd9,  4'd4, 4'd4);
    drive(8'd20, 8'd30, 4'd5, 4'd5);
    drive(8'd40, 8'd50, 4'd6, 4'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(io.out_valid), 32'd0);
    or_mode = 1;
    repeat (12) @(posedge clk);
    #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
